// File: rtl/score_pkg.sv
// Shared types and helpers for the pong score keeper.
package score_pkg;

    typedef enum logic [1:0] {
        ST_PLAY = 2'd0,
        ST_HOLD = 2'd1,
        ST_OVER = 2'd2
    } state_t;

    localparam int DEFAULT_WIN_SCORE = 11;

    // A zero-length pause still needs a one-bit counter to keep widths legal.
    function automatic int hold_cnt_w(input int cycles);
        int w;
        w = $clog2(cycles + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/edge_rise_detect.sv
// Per-bit rising-edge detector for the level-style point inputs.
module edge_rise_detect #(
    parameter int WIDTH = 2
) (
    input  logic             i_clk,
    input  logic [WIDTH-1:0] i_in,
    output logic [WIDTH-1:0] o_rise
);

    logic [WIDTH-1:0] r_hist;

    // History tracks the input even during reset, so a level held high across
    // reset release is seen as already-high and never scores.
    always_ff @(posedge i_clk) begin
        r_hist <= i_in;
    end

    assign o_rise = i_in & ~r_hist;

endmodule

// File: rtl/score_keeper.sv
// Multi-player score counter with post-point hold-off and game-over latch.
//   state   | meaning
//   ST_PLAY | accepting points; one rise scores, several rises collide
//   ST_HOLD | pause after a non-winning point; rises discarded
//   ST_OVER | winning score reached; everything frozen until restart
module score_keeper
    import score_pkg::*;
#(
    parameter int NUM_PLAYERS = 2,
    parameter int SCORE_W     = 5,
    parameter int WIN_SCORE   = DEFAULT_WIN_SCORE,
    parameter int HOLD_CYCLES = 16
) (
    input  logic                           i_clk,
    input  logic                           i_reset,
    input  logic [NUM_PLAYERS-1:0]         i_point_in,
    input  logic                           i_new_game,
    output logic [NUM_PLAYERS*SCORE_W-1:0] o_score,
    output logic [NUM_PLAYERS-1:0]         o_point_pulse,
    output logic                           o_collision,
    output logic                           o_hold,
    output logic                           o_game_over,
    output logic [NUM_PLAYERS-1:0]         o_winner
);

    localparam int CNT_W = hold_cnt_w(HOLD_CYCLES);
    localparam logic [CNT_W-1:0]   HOLD_LOAD = CNT_W'(HOLD_CYCLES);
    localparam logic [SCORE_W-1:0] NEAR_VAL  = SCORE_W'(WIN_SCORE - 1);

    generate
        if (NUM_PLAYERS < 2 || NUM_PLAYERS > 8) begin : g_bad_players
            $error("score_keeper: NUM_PLAYERS must be 2..8");
        end
        if (WIN_SCORE < 1 || WIN_SCORE > (2 ** SCORE_W) - 1) begin : g_bad_win
            $error("score_keeper: WIN_SCORE must be 1..2**SCORE_W-1");
        end
        if (HOLD_CYCLES < 0) begin : g_bad_hold
            $error("score_keeper: HOLD_CYCLES must be non-negative");
        end
    endgenerate

    logic [NUM_PLAYERS-1:0] w_rise;
    logic [NUM_PLAYERS-1:0] w_near;
    logic [NUM_PLAYERS-1:0] w_credit;
    logic                   w_multi;
    logic                   w_single;
    logic                   w_win_hit;
    logic                   w_clear;

    state_t                 r_state;
    logic [CNT_W-1:0]       r_hold_cnt;
    logic [NUM_PLAYERS-1:0] r_point_pulse;
    logic                   r_collision;
    logic                   r_hold;
    logic                   r_game_over;
    logic [NUM_PLAYERS-1:0] r_winner;
    logic [SCORE_W-1:0]     r_score [NUM_PLAYERS];

    edge_rise_detect #(
        .WIDTH (NUM_PLAYERS)
    ) u_edge (
        .i_clk  (i_clk),
        .i_in   (i_point_in),
        .o_rise (w_rise)
    );

    // x & (x-1) is non-zero exactly when two or more bits are set.
    assign w_multi   = |(w_rise & (w_rise - NUM_PLAYERS'(1)));
    assign w_single  = (|w_rise) & ~w_multi;
    assign w_clear   = ~i_reset | i_new_game;
    assign w_credit  = (r_state == ST_PLAY && w_single) ? w_rise : '0;
    assign w_win_hit = |(w_rise & w_near);

    generate
        for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_player
            assign w_near[g] = (r_score[g] == NEAR_VAL);
            assign o_score[g*SCORE_W +: SCORE_W] = r_score[g];

            always_ff @(posedge i_clk) begin
                if (w_clear) begin
                    r_score[g] <= '0;
                end else if (w_credit[g]) begin
                    r_score[g] <= r_score[g] + SCORE_W'(1);
                end
            end
        end
    endgenerate

    always_ff @(posedge i_clk) begin
        r_point_pulse <= '0;
        r_collision   <= 1'b0;
        if (w_clear) begin
            r_state     <= ST_PLAY;
            r_hold_cnt  <= '0;
            r_hold      <= 1'b0;
            r_game_over <= 1'b0;
            r_winner    <= '0;
        end else begin
            case (r_state)
                ST_PLAY: begin
                    if (w_single) begin
                        r_point_pulse <= w_rise;
                        if (w_win_hit) begin
                            r_state     <= ST_OVER;
                            r_game_over <= 1'b1;
                            r_winner    <= w_rise;
                        end else if (HOLD_CYCLES > 0) begin
                            r_state    <= ST_HOLD;
                            r_hold_cnt <= HOLD_LOAD;
                            r_hold     <= 1'b1;
                        end
                    end else if (w_multi) begin
                        r_collision <= 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (r_hold_cnt == CNT_W'(1)) begin
                        r_state    <= ST_PLAY;
                        r_hold_cnt <= '0;
                        r_hold     <= 1'b0;
                    end else begin
                        r_hold_cnt <= r_hold_cnt - CNT_W'(1);
                    end
                end
                ST_OVER: begin
                end
                default: begin
                    r_state <= ST_PLAY;
                end
            endcase
        end
    end

    assign o_point_pulse = r_point_pulse;
    assign o_collision   = r_collision;
    assign o_hold        = r_hold;
    assign o_game_over   = r_game_over;
    assign o_winner      = r_winner;

endmodule

// File: tb/tb_score_keeper.sv
// Random and directed bench for score_keeper against an abstract game model.
module tb_score_keeper;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_a, ng_a;
    logic [1:0]  pin_a;
    logic [9:0]  score_a;
    logic [1:0]  pulse_a, winner_a;
    logic        coll_a, hold_a, over_a;

    logic        reset_b, ng_b;
    logic [3:0]  pin_b;
    logic [19:0] score_b;
    logic [3:0]  pulse_b, winner_b;
    logic        coll_b, hold_b, over_b;

    score_keeper u_dut_a (
        .i_clk         (clk),
        .i_reset       (reset_a),
        .i_point_in    (pin_a),
        .i_new_game    (ng_a),
        .o_score       (score_a),
        .o_point_pulse (pulse_a),
        .o_collision   (coll_a),
        .o_hold        (hold_a),
        .o_game_over   (over_a),
        .o_winner      (winner_a)
    );

    score_keeper #(
        .NUM_PLAYERS (4),
        .SCORE_W     (5),
        .WIN_SCORE   (3),
        .HOLD_CYCLES (0)
    ) u_dut_b (
        .i_clk         (clk),
        .i_reset       (reset_b),
        .i_point_in    (pin_b),
        .i_new_game    (ng_b),
        .o_score       (score_b),
        .o_point_pulse (pulse_b),
        .o_collision   (coll_b),
        .o_hold        (hold_b),
        .o_game_over   (over_b),
        .o_winner      (winner_b)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Game model: scores as integers, pause as a remaining-cycle count.
    int m_score [2][8];
    int m_pulse [2];
    int m_coll  [2];
    int m_hold  [2];
    int m_over  [2];
    int m_win   [2];
    int m_prev  [2];

    task automatic model_step(input int k, input int np, input int win, input int hc,
                              input int pin, input bit rst_n, input bit ng);
        int rises;
        int nrise;
        int idx;
        rises = pin & ~m_prev[k] & ((1 << np) - 1);
        m_prev[k] = pin;
        m_pulse[k] = 0;
        m_coll[k] = 0;
        nrise = 0;
        idx = 0;
        for (int i = 0; i < np; i++) begin
            if (rises[i]) begin
                nrise++;
                idx = i;
            end
        end
        if (!rst_n || ng) begin
            for (int i = 0; i < 8; i++) m_score[k][i] = 0;
            m_hold[k] = 0;
            m_over[k] = 0;
            m_win[k]  = 0;
        end else if (m_over[k] != 0) begin
        end else if (m_hold[k] > 0) begin
            m_hold[k]--;
        end else if (nrise == 1) begin
            m_score[k][idx]++;
            m_pulse[k] = rises;
            if (m_score[k][idx] == win) begin
                m_over[k] = 1;
                m_win[k]  = rises;
            end else begin
                m_hold[k] = hc;
            end
        end else if (nrise > 1) begin
            m_coll[k] = 1;
        end
    endtask

    task automatic compare_all();
        logic [63:0] ea;
        logic [63:0] eb;
        ea = '0;
        eb = '0;
        for (int i = 0; i < 2; i++) ea |= 64'(m_score[0][i]) << (i * 5);
        for (int i = 0; i < 4; i++) eb |= 64'(m_score[1][i]) << (i * 5);
        chk("a_score",  score_a,  ea);
        chk("a_pulse",  pulse_a,  64'(m_pulse[0]));
        chk("a_coll",   coll_a,   64'(m_coll[0]));
        chk("a_hold",   hold_a,   64'(m_hold[0] > 0));
        chk("a_over",   over_a,   64'(m_over[0]));
        chk("a_winner", winner_a, 64'(m_win[0]));
        chk("b_score",  score_b,  eb);
        chk("b_pulse",  pulse_b,  64'(m_pulse[1]));
        chk("b_coll",   coll_b,   64'(m_coll[1]));
        chk("b_hold",   hold_b,   64'(m_hold[1] > 0));
        chk("b_over",   over_b,   64'(m_over[1]));
        chk("b_winner", winner_b, 64'(m_win[1]));
    endtask

    // Inputs are driven at the falling edge, the model steps on the rising
    // edge with the same values the DUT samples, outputs checked at the next fall.
    task automatic tick();
        @(posedge clk);
        model_step(0, 2, 11, 16, int'(pin_a), reset_a, ng_a);
        model_step(1, 4, 3, 0, int'(pin_b), reset_b, ng_b);
        @(negedge clk);
        compare_all();
    endtask

    task automatic wait_hold_clear_a();
        int n;
        n = 0;
        pin_a = 2'b00;
        while (hold_a === 1'b1 && n < 40) begin
            tick();
            n++;
        end
        chk("a_hold_clear", hold_a, 0);
    endtask

    initial begin
        int hold_len;
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 8; i++) m_score[k][i] = 0;
            m_pulse[k] = 0; m_coll[k] = 0; m_hold[k] = 0;
            m_over[k] = 0;  m_win[k] = 0;  m_prev[k] = 0;
        end
        reset_a = 1'b0; ng_a = 1'b0; pin_a = 2'b00;
        reset_b = 1'b0; ng_b = 1'b0; pin_b = 4'b0000;
        @(negedge clk);
        tick();
        tick();
        chk("rst_score_a", score_a, 0);
        chk("rst_over_a", over_a, 0);
        reset_a = 1'b1;
        reset_b = 1'b1;
        tick();

        // First point, then measure the pause and poke player 1 inside it.
        pin_a = 2'b01;
        tick();
        chk("p0_score", score_a[4:0], 1);
        chk("p0_pulse", pulse_a, 2'b01);
        chk("p0_hold", hold_a, 1);
        hold_len = 1;
        for (int n = 0; n < 40 && hold_a === 1'b1; n++) begin
            pin_a = (n == 4) ? 2'b10 : 2'b00;
            tick();
            if (hold_a === 1'b1) hold_len++;
        end
        chk("hold_len", hold_len, 16);
        chk("p1_ignored", score_a[9:5], 0);

        // Input held high across reset release must not score.
        pin_a = 2'b10;
        reset_a = 1'b0;
        tick();
        reset_a = 1'b1;
        tick();
        tick();
        chk("held_noscore", score_a, 0);
        pin_a = 2'b00;
        tick();
        pin_a = 2'b10;
        tick();
        chk("p1_after", score_a[9:5], 1);
        wait_hold_clear_a();

        // Simultaneous rises collide.
        pin_a = 2'b11;
        tick();
        chk("coll_pulse", coll_a, 1);
        chk("coll_score", score_a, 10'h020);
        pin_a = 2'b00;
        tick();
        chk("coll_drop", coll_a, 0);
        chk("coll_play", hold_a, 0);

        // Full game to player 1.
        ng_a = 1'b1;
        tick();
        ng_a = 1'b0;
        for (int p = 0; p < 11; p++) begin
            pin_a = 2'b10;
            tick();
            pin_a = 2'b00;
            if (p < 10) wait_hold_clear_a();
        end
        chk("win_score", score_a[9:5], 11);
        chk("win_over", over_a, 1);
        chk("win_who", winner_a, 2'b10);
        chk("win_hold", hold_a, 0);
        tick();
        pin_a = 2'b01;
        tick();
        chk("over_frozen", score_a, 10'd11 << 5);
        pin_a = 2'b00;
        ng_a = 1'b1;
        tick();
        ng_a = 1'b0;
        chk("ng_score", score_a, 0);
        chk("ng_over", over_a, 0);

        // new_game beats a simultaneous rise; reset mid-pause.
        pin_a = 2'b01;
        ng_a = 1'b1;
        tick();
        ng_a = 1'b0;
        chk("ng_prio_score", score_a, 0);
        chk("ng_prio_pulse", pulse_a, 0);
        pin_a = 2'b00;
        tick();
        pin_a = 2'b01;
        tick();
        pin_a = 2'b00;
        tick();
        tick();
        chk("mid_hold", hold_a, 1);
        reset_a = 1'b0;
        tick();
        reset_a = 1'b1;
        chk("rst_hold", hold_a, 0);
        chk("rst_scores", score_a, 0);

        // Four players, no pause, first to 3.
        for (int p = 1; p <= 3; p++) begin
            pin_b = 4'b0100;
            tick();
            chk("b_p2_score", score_b[14:10], p);
            pin_b = 4'b0000;
            tick();
        end
        chk("b_winner_dir", winner_b, 4'b0100);
        chk("b_over_dir", over_b, 1);
        ng_b = 1'b1;
        tick();
        ng_b = 1'b0;

        // Random traffic on both instances.
        for (int n = 0; n < 4000; n++) begin
            pin_a   = 2'($urandom_range(0, 3));
            pin_b   = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : pin_b;
            ng_a    = ($urandom_range(0, 399) == 0);
            ng_b    = ($urandom_range(0, 99) == 0);
            reset_a = ($urandom_range(0, 599) != 0);
            reset_b = ($urandom_range(0, 299) != 0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
